// File: rtl/ascon_aead_sequencer.sv
// Control FSM for the ASCON AEAD encrypt datapath: sequences init, AD absorb,
// plaintext encrypt and finalization, and drives the datapath and state-load selects.
module ascon_aead_sequencer #(
  parameter int SEL_W     = 3,
  parameter int PA_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             ad_none,
  input  logic             ad_valid,
  input  logic             ad_last,
  output logic             ad_ready,
  input  logic             txt_valid,
  input  logic             txt_last,
  output logic             txt_ready,
  output logic             txt_data_sel,
  output logic             permutation_category,
  output logic             p_out_sel,
  output logic             key_zero_exp_sel,
  output logic [SEL_W-1:0] state_sel,
  output logic             ct_valid,
  output logic             tag_valid,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_HOLD     = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_LOAD_IV  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_ABSORB   = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_PERM     = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_PERM_DS  = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_PERM_KEY = SEL_W'(5);
  localparam logic [SEL_W-1:0] SEL_DS_ONLY  = SEL_W'(6);

  // p^12 = PA_CYCLES chain passes; all but the last are raw passes, the last adds the key.
  localparam logic [3:0] PASS_LAST = 4'(PA_CYCLES - 2);

  typedef enum logic [3:0] {
    IDLE, LOAD, INIT_A, INIT_B, DS, AD_ABS, AD_P1, AD_P2,
    TXT_ABS, TXT_P1, TXT_P2, FIN_A, FIN_B, TAG
  } state_t;

  state_t     r_state, w_next;
  logic       r_mode, r_ad_none, r_ad_last;
  logic [3:0] r_pass, w_pass_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mode    <= 1'b0;
      r_ad_none <= 1'b0;
      r_ad_last <= 1'b0;
      r_pass    <= 4'd0;
    end else begin
      r_state <= w_next;
      r_pass  <= w_pass_next;
      if (r_state == IDLE && start) begin
        r_mode    <= mode;
        r_ad_none <= ad_none;
      end
      if (r_state == AD_ABS && ad_valid)
        r_ad_last <= ad_last;
    end
  end

  always_comb begin
    w_next               = r_state;
    w_pass_next          = 4'd0;
    state_sel            = SEL_HOLD;
    ad_ready             = 1'b0;
    txt_ready            = 1'b0;
    txt_data_sel         = 1'b0;
    p_out_sel            = 1'b0;
    key_zero_exp_sel     = 1'b0;
    ct_valid             = 1'b0;
    tag_valid            = 1'b0;
    busy                 = (r_state != IDLE);
    permutation_category = r_mode;
    case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: begin
        state_sel = SEL_LOAD_IV;
        w_next    = INIT_A;
      end
      INIT_A: begin
        state_sel = SEL_PERM;
        if (r_pass == PASS_LAST) w_next = INIT_B;
        else w_pass_next = r_pass + 4'd1;
      end
      INIT_B: begin
        state_sel = SEL_PERM_KEY;
        w_next    = r_ad_none ? DS : AD_ABS;
      end
      DS: begin
        state_sel = SEL_DS_ONLY;
        w_next    = TXT_ABS;
      end
      AD_ABS: begin
        ad_ready     = 1'b1;
        txt_data_sel = 1'b1;
        if (ad_valid) begin
          state_sel = SEL_ABSORB;
          w_next    = AD_P1;
        end
      end
      // ASCON-128a splits p^8 into a 6-round pass and a 2-round tap pass.
      AD_P1: begin
        if (r_mode) begin
          state_sel = SEL_PERM;
          w_next    = AD_P2;
        end else begin
          state_sel = r_ad_last ? SEL_PERM_DS : SEL_PERM;
          w_next    = r_ad_last ? TXT_ABS : AD_ABS;
        end
      end
      AD_P2: begin
        p_out_sel = 1'b1;
        state_sel = r_ad_last ? SEL_PERM_DS : SEL_PERM;
        w_next    = r_ad_last ? TXT_ABS : AD_ABS;
      end
      TXT_ABS: begin
        txt_ready = 1'b1;
        if (txt_valid) begin
          state_sel = SEL_ABSORB;
          ct_valid  = 1'b1;
          w_next    = txt_last ? FIN_A : TXT_P1;
        end
      end
      TXT_P1: begin
        state_sel = SEL_PERM;
        w_next    = r_mode ? TXT_P2 : TXT_ABS;
      end
      TXT_P2: begin
        p_out_sel = 1'b1;
        state_sel = SEL_PERM;
        w_next    = TXT_ABS;
      end
      FIN_A: begin
        state_sel = SEL_PERM;
        if (r_pass == PASS_LAST) w_next = FIN_B;
        else w_pass_next = r_pass + 4'd1;
      end
      FIN_B: begin
        state_sel        = SEL_PERM_KEY;
        key_zero_exp_sel = 1'b1;
        w_next           = TAG;
      end
      TAG: begin
        tag_valid = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
